// File: rtl/unsigned_mul_ha_pipe.sv
// Pipelined unsigned WIDTHxWIDTH multiplier built from half-adder row pairs.
// Stages: S1 registers operands, S2 registers per-pair HA array outputs,
// S3 registers the summed product. In approximate mode, cells whose column
// weight is below APPROX_COLS become OR cells and their carries are dropped.
// The pipeline advances as a single unit, so a stalled output holds every stage.
module unsigned_mul_ha_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_COLS = 4,
    parameter int unsigned TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_approx,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_approx,
    output logic [TAG_W-1:0]   out_tag,
    output logic [15:0]        approx_cnt
);

    localparam int unsigned PAIRS = WIDTH / 2;
    localparam int unsigned PW    = 2 * WIDTH;

    // Whole pipeline moves together; bubbles are not collapsed.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic             s1_approx;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic             s2_approx;
    logic [TAG_W-1:0] s2_tag;

    // Running sum of the shifted pair vectors; part[PAIRS] is the product.
    logic [PW-1:0] part [PAIRS+1];
    assign part[0] = '0;

    // S1: operand capture; data only loads on an accepted transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_approx <= 1'b0;
            s1_tag    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x      <= in_x;
                s1_y      <= in_y;
                s1_approx <= in_approx;
                s1_tag    <= in_tag;
            end
        end
    end

    for (genvar k = 0; k < PAIRS; k++) begin : g_pair
        // t: bit i sits at weight 2k+i; b: bit i sits at weight 2k+i+2.
        logic [WIDTH:0]   t_d;
        logic [WIDTH-2:0] b_d;
        logic [WIDTH:0]   t_q;
        logic [WIDTH-2:0] b_q;
        logic [PW-1:0]    pair_val;

        assign t_d[0]     = s1_y[0] & s1_x[2*k];
        assign t_d[WIDTH] = s1_y[WIDTH-1] & s1_x[2*k+1];

        for (genvar j = 1; j < WIDTH; j++) begin : g_cell
            localparam bit CellApprox = (2 * k + j) < int'(APPROX_COLS);
            logic a;
            logic b;
            logic or_mode;
            assign a        = s1_y[j] & s1_x[2*k];
            assign b        = s1_y[j-1] & s1_x[2*k+1];
            assign or_mode  = s1_approx & CellApprox;
            assign t_d[j]   = or_mode ? (a | b) : (a ^ b);
            assign b_d[j-1] = ~or_mode & a & b;
        end

        // S2: per-pair HA array outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                t_q <= '0;
                b_q <= '0;
            end else if (adv) begin
                t_q <= t_d;
                b_q <= b_d;
            end
        end

        assign pair_val  = {{(WIDTH-1){1'b0}}, t_q} + {{(WIDTH-1){1'b0}}, b_q, 2'b00};
        assign part[k+1] = part[k] + (pair_val << (2 * k));
    end

    // S2: control sideband travelling with the HA vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_approx <= 1'b0;
            s2_tag    <= '0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_approx <= s1_approx;
            s2_tag    <= s1_tag;
        end
    end

    // S3: product register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_product <= '0;
            out_approx  <= 1'b0;
            out_tag     <= '0;
        end else if (adv) begin
            out_valid   <= s2_valid;
            out_product <= part[PAIRS];
            out_approx  <= s2_approx;
            out_tag     <= s2_tag;
        end
    end

    // Count delivered approximate results; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            approx_cnt <= '0;
        end else if (out_valid && out_ready && out_approx) begin
            approx_cnt <= approx_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_unsigned_mul_ha_pipe.sv
// Self-checking bench for unsigned_mul_ha_pipe: directed cases, a random
// stream, a stall, a mid-flight reset and the approx counter wrap, all scored
// against an arithmetic reference model.
module tb_unsigned_mul_ha_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned AC = 4;
    localparam int unsigned TW = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_x;
    logic [W-1:0]    in_y;
    logic            in_approx;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_product;
    logic            out_approx;
    logic [TW-1:0]   out_tag;
    logic [15:0]     approx_cnt;

    unsigned_mul_ha_pipe #(
        .WIDTH      (W),
        .APPROX_COLS(AC),
        .TAG_W      (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_approx  (in_approx),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_approx (out_approx),
        .out_tag    (out_tag),
        .approx_cnt (approx_cnt)
    );

    typedef struct {
        logic [2*W-1:0] prod;
        logic [2*W-1:0] exact;
        logic           ap;
        logic [TW-1:0]  tag;
        int             acc_cyc;
        bit             lat;
    } exp_t;

    exp_t           q[$];
    exp_t           mon_e;
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic [15:0]    model_cnt = '0;
    logic [2*W-1:0] last_prod = '0;
    logic           last_ap = 1'b0;
    logic           held = 1'b0;
    logic [2*W-1:0] h_prod;
    logic [TW-1:0]  h_tag;
    logic           h_ap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: exact product minus the carry value each OR cell throws away.
    // A cell loses 2^w exactly when both of its inputs are 1.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic ap);
        longint p;
        p = longint'(x) * longint'(y);
        if (ap) begin
            for (int k = 0; k < int'(W / 2); k++) begin
                for (int j = 1; j < int'(W); j++) begin
                    if ((2 * k + j) < int'(AC) && y[j] && x[2*k] && y[j-1] && x[2*k+1]) begin
                        p = p - (longint'(1) << (2 * k + j));
                    end
                end
            end
        end
        return p[2*W-1:0];
    endfunction

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ap,
                        input logic [TW-1:0] tag, input bit lat);
        bit   acc;
        int   c;
        exp_t e;
        acc = 1'b0;
        c = 0;
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_approx = ap;
        in_tag    = tag;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (in_ready) begin
                acc = 1'b1;
                c = cyc;
            end
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        if (acc) begin
            e.prod    = ref_prod(x, y, ap);
            e.exact   = x * y;
            e.ap      = ap;
            e.tag     = tag;
            e.acc_cyc = c;
            e.lat     = lat;
            q.push_back(e);
        end else begin
            check("accept_timeout", 64'(acc), 64'(1));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check("drain", 64'(q.size()), 64'(0));
    endtask

    // Monitor: samples just before each rising edge, after inputs have settled.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            check("approx_cnt", 64'(approx_cnt), 64'(model_cnt));
            if (held) begin
                check("hold_prod", 64'(out_product), 64'(h_prod));
                check("hold_tag", 64'(out_tag), 64'(h_tag));
                check("hold_ap", 64'(out_approx), 64'(h_ap));
            end
            if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'(0));
            held   = out_valid && !out_ready;
            h_prod = out_product;
            h_tag  = out_tag;
            h_ap   = out_approx;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious", 64'(out_valid), 64'(0));
                end else begin
                    mon_e = q.pop_front();
                    check("product", 64'(out_product), 64'(mon_e.prod));
                    check("out_approx", 64'(out_approx), 64'(mon_e.ap));
                    check("out_tag", 64'(out_tag), 64'(mon_e.tag));
                    if (mon_e.lat) check("latency", 64'(cyc - mon_e.acc_cyc), 64'(3));
                    if (mon_e.ap) begin
                        check("approx_range",
                              64'((out_product <= mon_e.exact) &&
                                  (int'(out_product) + 22 >= int'(mon_e.exact))), 64'(1));
                        model_cnt = model_cnt + 16'd1;
                    end
                    last_prod = out_product;
                    last_ap   = out_approx;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_approx = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_product", 64'(out_product), 64'(0));
        check("rst_approx", 64'(out_approx), 64'(0));
        check("rst_tag", 64'(out_tag), 64'(0));
        check("rst_cnt", 64'(approx_cnt), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: all-ones operands, exact then approximate.
        send(8'hFF, 8'hFF, 1'b0, 4'h3, 1'b1);
        drain();
        check("tp_exact", 64'(last_prod), 64'(16'hFE01));
        send(8'hFF, 8'hFF, 1'b1, 4'h5, 1'b1);
        drain();
        check("tp_approx", 64'(last_prod), 64'(65003));
        check("tp_approx_flag", 64'(last_ap), 64'(1));
        check("tp_cnt", 64'(approx_cnt), 64'(1));

        // Random back-to-back stream with mixed modes.
        for (int i = 0; i < 100; i++) begin
            r = $urandom;
            send(r[7:0], r[15:8], r[16], r[20:17], 1'b1);
        end
        drain();

        // Stall with three in flight; a fourth waits on in_ready.
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            send(r[7:0], r[15:8], r[16], r[20:17], 1'b0);
        end
        out_ready = 1'b0;
        fork
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
            begin
                r = $urandom;
                send(r[7:0], r[15:8], r[16], r[20:17], 1'b0);
            end
        join
        drain();

        // Reset with two transactions in flight.
        send(8'hA5, 8'h3C, 1'b1, 4'h9, 1'b0);
        send(8'h7E, 8'hC3, 1'b0, 4'hA, 1'b0);
        rst_n = 1'b0;
        q.delete();
        model_cnt = '0;
        held = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_product", 64'(out_product), 64'(0));
        check("mid_rst_approx", 64'(out_approx), 64'(0));
        check("mid_rst_tag", 64'(out_tag), 64'(0));
        check("mid_rst_cnt", 64'(approx_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h12, 8'h34, 1'b0, 4'h6, 1'b1);
        drain();
        check("post_rst_product", 64'(last_prod), 64'(16'h03A8));

        // Drive the approximate counter to 0xFFFF, then wrap it.
        n = 65535 - int'(model_cnt);
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            send(r[7:0], r[15:8], 1'b1, r[19:16], 1'b0);
        end
        drain();
        check("cnt_ffff", 64'(approx_cnt), 64'(16'hFFFF));
        send(8'h0F, 8'hF0, 1'b1, 4'h1, 1'b0);
        drain();
        check("cnt_wrap", 64'(approx_cnt), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unsigned_mul_ha_pipe.md
Name: unsigned_mul_ha_pipe

Overview:
- Parametrised, pipelined unsigned WIDTHxWIDTH multiplier built around the half-adder row-pair array used by our approximate multiplier generators.
- A per-transaction mode selects exact products or approximate products. In approximate mode, low-weight half-adders become OR-sum cells and their carries are dropped.
- Sits between operand producers and accumulator/datapath consumers behind a valid/ready stream interface with a tag passthrough.

Parameters:
- WIDTH, 8, operand width; must be even and >= 4.
- APPROX_COLS, 4, absolute column weights w < APPROX_COLS use OR-sum cells in approximate mode; range 0..2*WIDTH-1.
- TAG_W, 4, width of the sideband tag carried alongside each transaction.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts the input when in_valid & in_ready.
- in_x  in  WIDTH  multiplicand.
- in_y  in  WIDTH  multiplier.
- in_approx  in  1  1 = approximate mode, 0 = exact.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result when out_valid & out_ready.
- out_product  out  2*WIDTH  product.
- out_approx  out  1  mode echo of the transaction.
- out_tag  out  TAG_W  tag echo.
- approx_cnt  out  16  count of approximate transactions delivered.

Behaviour:
- Reset (async assert, sync deassert is external): all stage valids=0, out_valid=0, out_product=0, out_approx=0, out_tag=0, approx_cnt=0. in_ready=1 after reset. Asserting reset mid-operation discards every in-flight transaction; nothing is emitted afterwards.
- Pipeline has 3 register stages: S1 operands, S2 HA arrays, S3 product. Latency is 3 cycles from accept to out_valid when there is no stall.
- Global advance: adv = ~out_valid | out_ready; in_ready = adv. All stages shift together when adv=1 and hold when adv=0.
- Bubbles are not collapsed. A stage with valid=0 still shifts. Throughput is 1 transaction/cycle while out_ready=1.
- Holding: out_product/out_approx/out_tag stay stable while out_valid & ~out_ready. Inputs are sampled only on in_valid & in_ready.
- S1->S2 (HA arrays): there are WIDTH/2 row pairs; pair k uses rows x[2k] and x[2k+1].
  - Cell j=1..WIDTH-1 at absolute weight w=2k+j takes a=y[j]&x[2k] and b=y[j-1]&x[2k+1].
  - Exact cell: half adder, sum at w, carry at w+1.
  - If in_approx=1 and w < APPROX_COLS: sum=a|b, carry=0.
  - Bit y[0]&x[2k] passes through at weight 2k. Bit y[WIDTH-1]&x[2k+1] passes through at weight 2k+WIDTH.
  - Registered as per-pair t (WIDTH+1 bits) and b (WIDTH-1 bits) vectors, same layout as our ha_array outputs.
- S2->S3: exact sum of all pair vectors, each shifted by its weight, truncated to 2*WIDTH bits. No overflow is possible.
- Exact mode must equal in_x*in_y bit-exactly. Approximate result <= exact result.
- approx_cnt increments by 1 on each out_valid & out_ready with out_approx=1 and wraps at 0xFFFF -> 0.
- APPROX_COLS=0 makes approximate mode identical to exact mode, but out_approx and approx_cnt still reflect the mode bit.

Test Plan:
- WIDTH=8, APPROX_COLS=4, x=0xFF, y=0xFF, approx=0, tag=0x3, out_ready=1. Expected: product 0xFE01 (65025), 3 cycles after accept, tag 0x3.
- Same operands with approx=1. Expected: product 65003 (losses 2+4+8 from pair0 columns 1..3, plus 8 from pair1 column 3), out_approx=1, approx_cnt=1.
- Stream 100 random operand pairs back-to-back with mixed modes and out_ready=1. Expected: one result per cycle in order; exact results match x*y; approximate results lie within [x*y-22, x*y] and match the reference model.
- Hold out_ready=0 for 5 cycles with 3 transactions in flight. Expected: in_ready=0 while out_valid=1; out_product stable; no loss or duplication after release.
- Assert rst_n low for one cycle with 2 transactions in flight. Expected: out_valid=0 immediately and all outputs 0; the next accepted transaction appears 3 cycles after accept.
- Force approx_cnt to 0xFFFF via 65535 approximate transactions, then send one more. Expected: approx_cnt=0x0000.
